// File: rtl/mpi_pkg.sv
// Shared definitions for the MPI bus initiator: bus widths, slave map,
// controller states, Rw encodings and the region-preserving address step.
package mpi_pkg;

    localparam int unsigned MPI_ADDR_W = 6;
    localparam int unsigned MPI_DATA_W = 8;

    // Slave map: RAM in the lower half, registers from REG_BASE upward.
    localparam logic [MPI_ADDR_W-1:0] REG_BASE  = 6'h20;
    localparam int unsigned           RAM_DEPTH = 32;
    localparam int unsigned           REG_DEPTH = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } mpi_state_e;

    // Bit 5 selects the region and is never touched; the low five bits wrap
    // mod 32 so a burst can never stray from RAM into registers or back.
    function automatic logic [MPI_ADDR_W-1:0] addr_step(input logic [MPI_ADDR_W-1:0] addr);
        logic [MPI_ADDR_W-2:0] low;
        low = addr[MPI_ADDR_W-2:0] + 5'd1;
        return {addr[MPI_ADDR_W-1], low};
    endfunction

    // True when the address decodes into the register region.
    function automatic logic in_reg_region(input logic [MPI_ADDR_W-1:0] addr);
        return addr[MPI_ADDR_W-1] == REG_BASE[MPI_ADDR_W-1];
    endfunction

endpackage

// File: rtl/mpi_addr_gen.sv
// Burst address and beat tracking for the MPI initiator. Holds the current
// beat address, the number of beats already completed and the burst length.
module mpi_addr_gen
    import mpi_pkg::*;
#(
    parameter int unsigned MAX_LEN_W = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  load,
    input  logic [MPI_ADDR_W-1:0] load_addr,
    input  logic [MAX_LEN_W-1:0]  load_len,
    input  logic                  step,
    output logic [MPI_ADDR_W-1:0] addr,
    output logic [MPI_ADDR_W-1:0] next_addr,
    output logic                  last
);

    // One extra bit so a full 2^MAX_LEN_W-beat burst never aliases to zero.
    logic [MAX_LEN_W:0]    count_q;
    logic [MAX_LEN_W-1:0]  len_q;
    logic [MPI_ADDR_W-1:0] addr_q;

    // Load a new burst, or advance address and beat count after each beat.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else if (load) begin
            addr_q  <= load_addr;
            count_q <= '0;
            len_q   <= load_len;
        end else if (step) begin
            addr_q  <= addr_step(addr_q);
            count_q <= count_q + 1'b1;
        end
    end

    // The beat in progress is the final one once len beats have completed.
    always_comb begin
        addr      = addr_q;
        next_addr = addr_step(addr_q);
        last      = (count_q == {1'b0, len_q});
    end

endmodule

// File: rtl/mpi_master.sv
// MPI bus initiator. Turns single/burst commands on a valid/ready port into
// MPI strobe sequences; write data arrives as a handshaked beat stream and
// read data leaves as a one-cycle-per-beat pulse stream. All bus-facing
// outputs, Rd_* and Busy are registered.
module mpi_master
    import mpi_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_LEN_W = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    // Command port
    input  logic                  Cmd_valid,
    output logic                  Cmd_ready,
    input  logic                  Cmd_rw,
    input  logic [MPI_ADDR_W-1:0] Cmd_addr,
    input  logic [MAX_LEN_W-1:0]  Cmd_len,
    // Write beat stream
    input  logic [MPI_DATA_W-1:0] Wr_data,
    input  logic                  Wr_valid,
    output logic                  Wr_ready,
    // Read beat stream
    output logic [MPI_DATA_W-1:0] Rd_data,
    output logic                  Rd_valid,
    output logic                  Rd_last,
    output logic                  Busy,
    // MPI bus
    output logic                  Mpi_enb,
    output logic                  Rw,
    output logic [MPI_ADDR_W-1:0] Mpi_addr,
    output logic [MPI_DATA_W-1:0] Mpi_wdata,
    input  logic [MPI_DATA_W-1:0] Mpi_rdata
);

    // Phase within a read beat: 0 is the strobe cycle, RD_LAT is the sample
    // cycle. Two bits cover the supported latencies of 1..3.
    localparam logic [1:0] LAT_END = 2'(RD_LAT);

    mpi_state_e            state_q;
    logic [1:0]            phase_q;

    logic                  cmd_fire;
    logic                  wr_fire;
    logic                  rd_sample;
    logic                  ag_step;
    logic [MPI_ADDR_W-1:0] cur_addr;
    logic [MPI_ADDR_W-1:0] nxt_addr;
    logic                  beat_last;

    // Handshake qualifiers; both ports are closed while Reset is high.
    always_comb begin
        Cmd_ready = (state_q == IDLE) & ~Reset;
        Wr_ready  = (state_q == WRITE) & ~Reset;
        cmd_fire  = Cmd_valid & Cmd_ready;
        wr_fire   = Wr_valid & Wr_ready;
        rd_sample = (state_q == READ) & (phase_q == LAT_END);
        ag_step   = wr_fire | rd_sample;
    end

    mpi_addr_gen #(
        .MAX_LEN_W (MAX_LEN_W)
    ) u_addr_gen (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (cmd_fire),
        .load_addr (Cmd_addr),
        .load_len  (Cmd_len),
        .step      (ag_step),
        .addr      (cur_addr),
        .next_addr (nxt_addr),
        .last      (beat_last)
    );

    // Controller FSM with registered bus, read-stream and Busy outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            Mpi_enb   <= 1'b0;
            Rw        <= RW_READ;
            Mpi_addr  <= '0;
            Mpi_wdata <= '0;
            Rd_data   <= '0;
            Rd_valid  <= 1'b0;
            Rd_last   <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle; Rw parks at read whenever idle on the bus.
            Mpi_enb  <= 1'b0;
            Rw       <= RW_READ;
            Rd_valid <= 1'b0;
            Rd_last  <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        Busy <= 1'b1;
                        if (Cmd_rw == RW_READ) begin
                            // First read strobe goes out in the first READ cycle.
                            state_q  <= READ;
                            phase_q  <= '0;
                            Mpi_enb  <= 1'b1;
                            Mpi_addr <= Cmd_addr;
                        end else begin
                            state_q <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    // Address is held through gaps; only a handshake moves the bus.
                    if (wr_fire) begin
                        Mpi_enb   <= 1'b1;
                        Rw        <= RW_WRITE;
                        Mpi_addr  <= cur_addr;
                        Mpi_wdata <= Wr_data;
                        if (beat_last) begin
                            state_q <= IDLE;
                            Busy    <= 1'b0;
                        end
                    end
                end

                READ: begin
                    if (phase_q != LAT_END) begin
                        // Latency cycles: address held so register reads stay stable.
                        phase_q <= phase_q + 2'd1;
                    end else begin
                        Rd_data  <= Mpi_rdata;
                        Rd_valid <= 1'b1;
                        Rd_last  <= beat_last;
                        phase_q  <= '0;
                        if (beat_last) begin
                            state_q <= IDLE;
                            Busy    <= 1'b0;
                        end else begin
                            Mpi_enb  <= 1'b1;
                            Mpi_addr <= nxt_addr;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpi_master.sv
// Self-checking bench for mpi_master: directed commands against a small
// RAM+register slave model, with a queue-based scoreboard checked by a
// negedge monitor.
`timescale 1ns/1ps
module tb_mpi_master;
    import mpi_pkg::*;

    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned MAX_LEN_W = 4;

    logic                  Clock = 1'b0;
    logic                  Reset;
    logic                  Cmd_valid;
    logic                  Cmd_ready;
    logic                  Cmd_rw;
    logic [MPI_ADDR_W-1:0] Cmd_addr;
    logic [MAX_LEN_W-1:0]  Cmd_len;
    logic [MPI_DATA_W-1:0] Wr_data;
    logic                  Wr_valid;
    logic                  Wr_ready;
    logic [MPI_DATA_W-1:0] Rd_data;
    logic                  Rd_valid;
    logic                  Rd_last;
    logic                  Busy;
    logic                  Mpi_enb;
    logic                  Rw;
    logic [MPI_ADDR_W-1:0] Mpi_addr;
    logic [MPI_DATA_W-1:0] Mpi_wdata;
    logic [MPI_DATA_W-1:0] Mpi_rdata;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mpi_master #(
        .RD_LAT    (RD_LAT),
        .MAX_LEN_W (MAX_LEN_W)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Cmd_valid (Cmd_valid),
        .Cmd_ready (Cmd_ready),
        .Cmd_rw    (Cmd_rw),
        .Cmd_addr  (Cmd_addr),
        .Cmd_len   (Cmd_len),
        .Wr_data   (Wr_data),
        .Wr_valid  (Wr_valid),
        .Wr_ready  (Wr_ready),
        .Rd_data   (Rd_data),
        .Rd_valid  (Rd_valid),
        .Rd_last   (Rd_last),
        .Busy      (Busy),
        .Mpi_enb   (Mpi_enb),
        .Rw        (Rw),
        .Mpi_addr  (Mpi_addr),
        .Mpi_wdata (Mpi_wdata),
        .Mpi_rdata (Mpi_rdata)
    );

    // Slave model: registered RAM read (one cycle), combinational registers.
    logic [7:0] ram  [0:31];
    logic [7:0] regs [0:15];
    logic [7:0] ram_q;

    always @(posedge Clock) begin
        if (Mpi_enb && !Rw) begin
            if (Mpi_addr[5]) regs[Mpi_addr[3:0]] <= Mpi_wdata;
            else             ram[Mpi_addr[4:0]]  <= Mpi_wdata;
        end
        if (Mpi_enb && Rw) ram_q <= ram[Mpi_addr[4:0]];
    end

    assign Mpi_rdata = Mpi_addr[5] ? regs[Mpi_addr[3:0]] : ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: {addr,data} bus writes, read strobe addresses, {data,last} read beats.
    logic [13:0] wr_exp [$];
    logic [5:0]  ra_exp [$];
    logic [8:0]  rd_exp [$];

    logic        prev_rd_enb = 1'b0;
    logic [5:0]  prev_addr   = '0;
    int          rd_seen     = 0;
    logic [13:0] w_item;
    logic [5:0]  a_item;
    logic [8:0]  r_item;

    // Monitor: compares every bus cycle and read beat against the queues.
    always @(negedge Clock) begin
        if (Reset) begin
            prev_rd_enb = 1'b0;
        end else begin
            if (prev_rd_enb) begin
                chk("rd_addr_hold", 32'(Mpi_addr), 32'(prev_addr));
                chk("rd_enb_gap", 32'(Mpi_enb), 32'(0));
            end
            prev_rd_enb = Mpi_enb && Rw;
            prev_addr   = Mpi_addr;
            if (!Mpi_enb) chk("rw_parks_read", 32'(Rw), 32'(1));
            if (Mpi_enb && !Rw) begin
                if (wr_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                             Mpi_addr, Mpi_wdata);
                end else begin
                    w_item = wr_exp.pop_front();
                    chk("wr_addr", 32'(Mpi_addr), 32'(w_item[13:8]));
                    chk("wr_data", 32'(Mpi_wdata), 32'(w_item[7:0]));
                end
            end
            if (Mpi_enb && Rw) begin
                if (ra_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read_strobe: got addr 0x%0h, expected none",
                             Mpi_addr);
                end else begin
                    a_item = ra_exp.pop_front();
                    chk("rd_strobe_addr", 32'(Mpi_addr), 32'(a_item));
                end
            end
            if (Rd_valid) begin
                rd_seen++;
                if (rd_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd_valid: got data 0x%0h, expected none", Rd_data);
                end else begin
                    r_item = rd_exp.pop_front();
                    chk("rd_data", 32'(Rd_data), 32'(r_item[8:1]));
                    chk("rd_last", 32'(Rd_last), 32'(r_item[0]));
                end
            end
        end
    end

    task automatic send_cmd(input logic rw, input logic [5:0] a, input logic [3:0] len);
        int n = 0;
        Cmd_valid = 1'b1; Cmd_rw = rw; Cmd_addr = a; Cmd_len = len;
        @(negedge Clock);
        while (!Cmd_ready && n < 50) begin @(negedge Clock); n++; end
        if (!Cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_handshake: got no Cmd_ready, expected one within 50 cycles");
        end
        @(posedge Clock); #1;
        Cmd_valid = 1'b0;
    endtask

    task automatic wr_beat(input logic [7:0] d);
        int n = 0;
        Wr_valid = 1'b1; Wr_data = d;
        @(negedge Clock);
        while (!Wr_ready && n < 50) begin @(negedge Clock); n++; end
        if (!Wr_ready) begin
            checks++; errors++;
            $display("FAIL wr_handshake: got no Wr_ready, expected one within 50 cycles");
        end
        @(posedge Clock); #1;
        Wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (Busy && n < 200) begin @(posedge Clock); #1; n++; end
        if (Busy) begin
            checks++; errors++;
            $display("FAIL %s_idle: got Busy=1, expected 0 within 200 cycles", name);
        end
        repeat (3) @(posedge Clock);
        #1;
    endtask

    initial begin
        int n;
        Reset = 1'b1; Cmd_valid = 1'b0; Cmd_rw = 1'b1; Cmd_addr = '0; Cmd_len = '0;
        Wr_valid = 1'b0; Wr_data = '0;

        // Reset values, with a write command offered during Reset.
        Cmd_valid = 1'b1; Cmd_rw = 1'b0; Cmd_addr = 6'h05;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_enb", 32'(Mpi_enb), 32'(0));
        chk("rst_rw", 32'(Rw), 32'(1));
        chk("rst_addr", 32'(Mpi_addr), 32'(0));
        chk("rst_wdata", 32'(Mpi_wdata), 32'(0));
        chk("rst_rd_valid", 32'(Rd_valid), 32'(0));
        chk("rst_rd_last", 32'(Rd_last), 32'(0));
        chk("rst_rd_data", 32'(Rd_data), 32'(0));
        chk("rst_busy", 32'(Busy), 32'(0));
        chk("rst_cmd_ready", 32'(Cmd_ready), 32'(0));
        chk("rst_wr_ready", 32'(Wr_ready), 32'(0));
        Cmd_valid = 1'b0;
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("no_accept_in_reset", 32'(Busy), 32'(0));
        chk("cmd_ready_idle", 32'(Cmd_ready), 32'(1));

        // Single write 0x05 <= 0xA5.
        wr_exp.push_back({6'h05, 8'hA5});
        send_cmd(1'b0, 6'h05, 4'd0);
        chk("wr_busy", 32'(Busy), 32'(1));
        chk("wr_ready_open", 32'(Wr_ready), 32'(1));
        wr_beat(8'hA5);
        chk("single_enb", 32'(Mpi_enb), 32'(1));
        @(posedge Clock); #1;
        chk("single_enb_once", 32'(Mpi_enb), 32'(0));
        chk("single_busy_low", 32'(Busy), 32'(0));
        wait_idle("single_wr");

        // RAM preload across the RAM wrap: 0x1E,0x1F,0x00,0x01 <= 0x10..0x13.
        wr_exp.push_back({6'h1E, 8'h10});
        wr_exp.push_back({6'h1F, 8'h11});
        wr_exp.push_back({6'h00, 8'h12});
        wr_exp.push_back({6'h01, 8'h13});
        send_cmd(1'b0, 6'h1E, 4'd3);
        wr_beat(8'h10); wr_beat(8'h11); wr_beat(8'h12); wr_beat(8'h13);
        wait_idle("preload");

        // Read burst back across the wrap; Rd_last on the fourth beat only.
        ra_exp.push_back(6'h1E); ra_exp.push_back(6'h1F);
        ra_exp.push_back(6'h00); ra_exp.push_back(6'h01);
        rd_exp.push_back({8'h10, 1'b0}); rd_exp.push_back({8'h11, 1'b0});
        rd_exp.push_back({8'h12, 1'b0}); rd_exp.push_back({8'h13, 1'b1});
        send_cmd(1'b1, 6'h1E, 4'd3);
        wait_idle("rd_burst");
        chk("rd_burst_drained", 32'(rd_exp.size()), 32'(0));

        // Register-region wrap: 0x3E,0x3F,0x20.
        wr_exp.push_back({6'h3E, 8'h11});
        wr_exp.push_back({6'h3F, 8'h22});
        wr_exp.push_back({6'h20, 8'h33});
        send_cmd(1'b0, 6'h3E, 4'd2);
        wr_beat(8'h11); wr_beat(8'h22); wr_beat(8'h33);
        wait_idle("reg_wr");

        // Register read-back through the same wrap.
        ra_exp.push_back(6'h3E); ra_exp.push_back(6'h3F); ra_exp.push_back(6'h20);
        rd_exp.push_back({8'h11, 1'b0}); rd_exp.push_back({8'h22, 1'b0});
        rd_exp.push_back({8'h33, 1'b1});
        send_cmd(1'b1, 6'h3E, 4'd2);
        wait_idle("reg_rd");

        // Write with gaps: Wr_valid 1,0,0,1 at 0x08.
        wr_exp.push_back({6'h08, 8'h5A});
        wr_exp.push_back({6'h09, 8'hC3});
        send_cmd(1'b0, 6'h08, 4'd1);
        wr_beat(8'h5A);
        @(posedge Clock); #1;
        chk("gap1_enb", 32'(Mpi_enb), 32'(0));
        chk("gap1_addr", 32'(Mpi_addr), 32'(6'h08));
        @(posedge Clock); #1;
        chk("gap2_enb", 32'(Mpi_enb), 32'(0));
        chk("gap2_addr", 32'(Mpi_addr), 32'(6'h08));
        wr_beat(8'hC3);
        wait_idle("gap_wr");

        // Single-beat read of the first write.
        ra_exp.push_back(6'h05);
        rd_exp.push_back({8'hA5, 1'b1});
        send_cmd(1'b1, 6'h05, 4'd0);
        wait_idle("single_rd");

        // Reset during beat 2 of a len=7 read from 0x1E.
        ra_exp.push_back(6'h1E); ra_exp.push_back(6'h1F); ra_exp.push_back(6'h00);
        rd_exp.push_back({8'h10, 1'b0}); rd_exp.push_back({8'h11, 1'b0});
        n = rd_seen;
        send_cmd(1'b1, 6'h1E, 4'd7);
        for (int i = 0; i < 50; i++) begin
            @(posedge Clock);
            if (rd_seen >= n + 2) break;
        end
        chk("mid_rd_two_beats", 32'(rd_seen - n), 32'(2));
        #1 Reset = 1'b1;
        @(posedge Clock); #1;
        chk("mid_rst_enb", 32'(Mpi_enb), 32'(0));
        chk("mid_rst_rw", 32'(Rw), 32'(1));
        chk("mid_rst_busy", 32'(Busy), 32'(0));
        chk("mid_rst_rd_valid", 32'(Rd_valid), 32'(0));
        chk("mid_rst_addr", 32'(Mpi_addr), 32'(0));
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("post_rst_cmd_ready", 32'(Cmd_ready), 32'(1));
        repeat (10) @(posedge Clock);
        #1;

        chk("wr_queue_empty", 32'(wr_exp.size()), 32'(0));
        chk("ra_queue_empty", 32'(ra_exp.size()), 32'(0));
        chk("rd_queue_empty", 32'(rd_exp.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected one before 200us");
        $fatal(1, "timeout");
    end

endmodule
